// File: rtl/quiz_seq_ctrl.sv
// Game sequencer for the factorization quiz board: IDLE -> READY -> QUESTION -> INPUT -> RESULT.
// Define QUIZ_SEQ_FAST_SIM_EN to drop the prescaler so every cycle is a tick.
module quiz_seq_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int READY_TICKS  = 2,
  parameter int QUE_TICKS    = 3,
  parameter int RESULT_TICKS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ENTER,
  input  logic [3:0] ANSWER,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] SEG_Q,
  output logic       CORRECT,
  output logic       WRONG,
  output logic       BUSY
);

  localparam int MAX_A     = (READY_TICKS > QUE_TICKS) ? READY_TICKS : QUE_TICKS;
  localparam int MAX_TICKS = (MAX_A > RESULT_TICKS) ? MAX_A : RESULT_TICKS;
  localparam int DW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_READY    = 4'b0010,
    S_QUESTION = 4'b0011,
    S_INPUT    = 4'b0100,
    S_RESULT   = 4'b0101
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    que_q, que_d;
  logic [3:0]    seg_cnt_q, seg_cnt_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          state_chg;
  logic          ready_done, que_done, result_done;
  logic [3:0]    cand;
  logic [3:0]    digit;

  assign state_chg = (state_d != state_q);

`ifdef QUIZ_SEQ_FAST_SIM_EN
  assign tick = 1'b1;
`else
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Restarting on a state change makes every dwell a whole number of tick periods.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (state_chg || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`endif

  assign ready_done  = tick && (dwell_q == DW'(READY_TICKS - 1));
  assign que_done    = tick && (dwell_q == DW'(QUE_TICKS - 1));
  assign result_done = tick && (dwell_q == DW'(RESULT_TICKS - 1));

  // x^8 + x^6 + x^5 + x^4 + 1 is primitive, so a non-zero seed never reaches zero.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand   = lfsr_q[3:0];
  assign digit  = (cand < 4'd10) ? cand : cand - 4'd6;

  always_comb begin
    state_d   = state_q;
    que_d     = que_q;
    seg_cnt_d = seg_cnt_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;

    case (state_q)
      S_IDLE: begin
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        if (START) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (ready_done) begin
          state_d = S_QUESTION;
          que_d   = digit;
        end
      end
      S_QUESTION: begin
        if (que_done) begin
          state_d   = S_INPUT;
          seg_cnt_d = 4'd0;
        end
      end
      S_INPUT: begin
        // ENTER is judged even when it lands on the timeout tick.
        if (ENTER) begin
          state_d   = S_RESULT;
          correct_d = (ANSWER == que_q);
          wrong_d   = (ANSWER != que_q);
        end else if (tick) begin
          if (seg_cnt_q == 4'd9) begin
            state_d   = S_RESULT;
            correct_d = 1'b0;
            wrong_d   = 1'b1;
          end else begin
            seg_cnt_d = seg_cnt_q + 4'd1;
          end
        end
      end
      S_RESULT: begin
        if (START) begin
          state_d   = S_READY;
          correct_d = 1'b0;
          wrong_d   = 1'b0;
        end else if (result_done) begin
          state_d   = S_IDLE;
          correct_d = 1'b0;
          wrong_d   = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_READY) || (state_d == S_QUESTION) || (state_d == S_INPUT);
  end

  always_comb begin
    dwell_d = dwell_q;
    if (state_chg) begin
      dwell_d = '0;
    end else if (tick) begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 8'h01;
      dwell_q   <= '0;
      que_q     <= 4'd0;
      seg_cnt_q <= 4'd0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      dwell_q   <= dwell_d;
      que_q     <= que_d;
      seg_cnt_q <= seg_cnt_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      busy_q    <= busy_d;
    end
  end

  assign STATE   = state_q;
  assign QUE     = que_q;
  assign SEG_Q   = seg_cnt_q;
  assign CORRECT = correct_q;
  assign WRONG   = wrong_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_quiz_seq_ctrl.sv
// Scoreboard bench for quiz_seq_ctrl: each game's expected output timeline is queued when the game
// is launched, and a monitor matches every observed output change against the queue head.
`timescale 1ns/1ps
module tb_quiz_seq_ctrl;

  localparam int TD = 3;
  localparam int RT = 2;
  localparam int QT = 3;
  localparam int ST = 3;
`ifdef QUIZ_SEQ_FAST_SIM_EN
  localparam int TDE = 1;
`else
  localparam int TDE = TD;
`endif

  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_READY = 4'd2;
  localparam logic [3:0] S_QUES  = 4'd3;
  localparam logic [3:0] S_INPUT = 4'd4;
  localparam logic [3:0] S_RES   = 4'd5;
  localparam logic [14:0] RST_SNAP = {S_IDLE, 4'd0, 4'd0, 3'b000};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ENTER = 1'b0;
  logic [3:0] ANSWER = 4'd0;
  logic [3:0] STATE, QUE, SEG_Q;
  logic       CORRECT, WRONG, BUSY;

  quiz_seq_ctrl #(
    .TICK_DIV(TD), .READY_TICKS(RT), .QUE_TICKS(QT), .RESULT_TICKS(ST)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ENTER(ENTER), .ANSWER(ANSWER),
    .STATE(STATE), .QUE(QUE), .SEG_Q(SEG_Q), .CORRECT(CORRECT), .WRONG(WRONG), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // cyc == number of rising edges since reset release; period n lies between edge n and edge n+1.
  int cyc;
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [14:0] prev = RST_SNAP;
  logic [3:0]  m_que = 4'd0;
  logic [3:0]  m_seg = 4'd0;

  function automatic logic [7:0] lfsr_at(int n);
    logic [7:0] x = 8'h01;
    for (int k = 0; k < n; k++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    return x;
  endfunction

  function automatic logic [3:0] digit_of(logic [7:0] x);
    int d = int'(x[3:0]);
    return (d < 10) ? 4'(d) : 4'(d - 6);
  endfunction

  function automatic void push(int c, logic [3:0] st, logic [3:0] q, logic [3:0] s,
                               logic cor, logic wr, logic busy);
    exp_t e;
    e.cyc = c;
    e.v   = {st, q, s, cor, wr, busy};
    exp_q.push_back(e);
  endfunction

  task automatic monitor();
    logic [14:0] now;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        now = {STATE, QUE, SEG_Q, CORRECT, WRONG, BUSY};
        if (now !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, now, prev);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || now !== e.v) begin
              errors++;
              $display("FAIL output_event got cyc=%0d val=%h required cyc=%0d val=%h", cyc, now, e.cyc, e.v);
            end else begin
              $display("event cyc=%0d state=%h que=%0d seg=%0d cor=%b wr=%b busy=%b",
                       cyc, STATE, QUE, SEG_Q, CORRECT, WRONG, BUSY);
            end
          end
          prev = now;
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          checks++;
          errors++;
          e = exp_q.pop_front();
          $display("FAIL missing_event cyc=%0d got=%h required cyc=%0d val=%h", cyc, now, e.cyc, e.v);
        end
      end
    end
  endtask

  task automatic check_reset(input string name);
    logic [14:0] now;
    now = {STATE, QUE, SEG_Q, CORRECT, WRONG, BUSY};
    checks++;
    if (now !== RST_SNAP) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, now, RST_SNAP);
    end else begin
      $display("reset check %s state=%h que=%0d seg=%0d busy=%b", name, STATE, QUE, SEG_Q, BUSY);
    end
  endtask

  // Called on the falling edge of period c0 with START already high for that period.
  // enter_off < 0 means timeout; rs_off >= 0 restarts from RESULT after that many periods.
  task automatic play(input int c0, input int enter_off, input bit right, input int rs_off,
                      input bit abort, output int next_c);
    int         r, q, i, last, s, endp, u;
    logic [3:0] ans;
    logic       cor;
    r = c0 + 1;
    q = r + RT * TDE;
    i = q + QT * TDE;
    push(r, S_READY, m_que, m_seg, 1'b0, 1'b0, 1'b1);
    m_que = digit_of(lfsr_at(q - 1));
    push(q, S_QUES, m_que, m_seg, 1'b0, 1'b0, 1'b1);
    m_seg = 4'd0;
    push(i, S_INPUT, m_que, 4'd0, 1'b0, 1'b0, 1'b1);
    last = (enter_off < 0) ? i + 10 * TDE - 1 : i + enter_off;
    for (int j = 1; j <= 9; j++)
      if (i + j * TDE <= last) push(i + j * TDE, S_INPUT, m_que, 4'(j), 1'b0, 1'b0, 1'b1);
    s   = last + 1;
    ans = 4'd0;
    if (enter_off < 0) begin
      cor   = 1'b0;
      m_seg = 4'd9;
    end else begin
      m_seg = 4'(enter_off / TDE);
      u     = $urandom_range(0, 8);
      ans   = right ? m_que : 4'((int'(m_que) + 1 + u) % 10);
      cor   = right;
    end
    if (abort) begin
      endp = i + 2;
    end else begin
      push(s, S_RES, m_que, m_seg, cor, !cor, 1'b0);
      if (rs_off >= 0) begin
        endp = s + rs_off;
      end else begin
        endp = s + ST * TDE;
        push(endp, S_IDLE, m_que, m_seg, 1'b0, 1'b0, 1'b0);
      end
    end
    next_c = endp;
    for (int p = c0 + 1; p <= endp; p++) begin
      @(negedge CLK);
      START  = 1'b0;
      ENTER  = 1'b0;
      ANSWER = 4'($urandom_range(0, 15));
      if (!abort && enter_off >= 0 && p == last) begin
        ENTER  = 1'b1;
        ANSWER = ans;
      end else if ((p < i || p >= s) && $urandom_range(0, 7) == 0) begin
        ENTER = 1'b1;
      end
      if (p < s && $urandom_range(0, 7) == 0) START = 1'b1;
      if (!abort && rs_off >= 0 && p == endp) START = 1'b1;
    end
  endtask

  task automatic idle_then_start(output int c);
    int n = $urandom_range(1, 4);
    repeat (n) begin
      @(negedge CLK);
      START = 1'b0;
      ENTER = ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    ENTER = 1'b0;
    START = 1'b1;
    c     = cyc;
  endtask

  task automatic mid_reset();
    mon_en = 1'b0;
    #2 RST = 1'b1;
    #1 check_reset("async_reset_mid_game");
    exp_q.delete();
    START = 1'b0;
    ENTER = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b0;
    m_que  = 4'd0;
    m_seg  = 4'd0;
    prev   = RST_SNAP;
    mon_en = 1'b1;
  endtask

  initial begin
    int c, nc, eo, rs;
    fork
      monitor();
    join_none
    #8 check_reset("reset_hold");
    #4 RST = 1'b0;
    prev   = RST_SNAP;
    mon_en = 1'b1;
    repeat (4) @(negedge CLK);
    START = 1'b1;
    c     = cyc;
    play(c, -1, 1'b0, -1, 1'b0, nc);                 // timeout
    idle_then_start(c);
    play(c, 4 * TDE + TDE / 2, 1'b1, -1, 1'b0, nc);  // right answer while SEG_Q==4
    idle_then_start(c);
    play(c, 10 * TDE - 1, 1'b1, -1, 1'b0, nc);       // ENTER on the timeout tick
    idle_then_start(c);
    play(c, 2 * TDE, 1'b0, 1, 1'b0, nc);             // wrong answer, restart from RESULT
    c = nc;
    for (int g = 0; g < 25; g++) begin
      eo = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 10 * TDE - 1);
      rs = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ST * TDE - 1) : -1;
      play(c, eo, 1'($urandom_range(0, 1)), rs, 1'b0, nc);
      if (rs >= 0) c = nc;
      else idle_then_start(c);
    end
    play(c, -1, 1'b0, -1, 1'b1, nc);                 // abandoned in INPUT by reset
    mid_reset();
    idle_then_start(c);
    play(c, TDE, 1'b1, -1, 1'b0, nc);
    repeat (4) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
